// File: rtl/bs_zlib_packer.sv
// bs_zlib_packer: zlib framer and LSB-first bit packer for pre-coded fixed-Huffman tokens.
// The stream is the CMF/FLG header, then one or more blocks (BFINAL/BTYPE=01 header, tokens,
// 7-bit EOB), byte alignment and a big-endian Adler-32. It leaves as OUT_WD-bit words
// with valid/ready backpressure.
// Optional feature macro: BS_ZLIB_LEN_TRAILER_EN appends the zlib byte count as a 4-byte
// big-endian trailer after the Adler-32. The count itself does not include the trailer.
module bs_zlib_packer #(
    parameter int          OUT_WD   = 32,
    parameter int          CODE_WD  = 19,
    parameter int          LEN_WD   = 5,
    parameter logic [15:0] ZLIB_HDR = 16'h7801
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               tok_val_i,
    output logic               tok_rdy_o,
    input  logic [CODE_WD-1:0] tok_code_i,
    input  logic [LEN_WD-1:0]  tok_len_i,
    input  logic               tok_eob_i,
    input  logic               tok_fin_i,
    input  logic               adler32_done_i,
    input  logic [31:0]        adler32_dat_i,
    output logic               out_val_o,
    input  logic               out_rdy_i,
    output logic [OUT_WD-1:0]  out_dat_o,
    output logic               out_lst_o,
    output logic [31:0]        zlib_len_o,
    output logic               done_o
);

    localparam int ACC_WD = 2*OUT_WD + 32;
    localparam int CNT_WD = $clog2(ACC_WD + 1);
    localparam logic [CNT_WD-1:0] OUT_WD_C = CNT_WD'(OUT_WD);
    localparam logic [CNT_WD-1:0] OUT_MASK = CNT_WD'(OUT_WD - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_BHDR,
        S_DATA,
        S_EOB,
        S_ALIGN,
        S_ADLER,
        S_LEN,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [ACC_WD-1:0]   r_acc;
    logic [CNT_WD-1:0]   r_cnt;
    logic                r_fin;
    logic                r_adlerFlag;
    logic [31:0]         r_adlerDat;
    logic [31:0]         r_bitCnt;
    logic [31:0]         r_zlibLen;
    logic                r_outVal;
    logic [OUT_WD-1:0]   r_outDat;
    logic                r_outLst;
    logic                r_done;

    logic                w_pushOk;
    logic                w_popOk;
    logic                w_push;
    logic [31:0]         w_pushDat;
    logic [CNT_WD-1:0]   w_pushLen;
    logic [31:0]         w_mask;
    logic [31:0]         w_pushMasked;
    logic [ACC_WD-1:0]   w_pushVec;
    logic [CNT_WD-1:0]   w_cntBase;
    logic [ACC_WD-1:0]   w_accShift;
    logic [ACC_WD-1:0]   w_accNxt;
    logic [CNT_WD-1:0]   w_cntNxt;
    logic [2:0]          w_alignPad;
    logic [CNT_WD-1:0]   w_flushPad;
    logic                w_countBits;
    logic                w_lstHs;

    // Multi-byte fields go out MSB-byte first while every byte goes out LSB-first,
    // so the most significant byte has to land in the lowest accumulator bits.
    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    assign w_pushOk   = (r_cnt <= OUT_WD_C);
    assign w_popOk    = (!r_outVal || out_rdy_i) &&
                        ((r_cnt > OUT_WD_C) || ((r_state == S_DRAIN) && (r_cnt >= OUT_WD_C)));
    assign w_alignPad = 3'd0 - r_cnt[2:0];
    assign w_flushPad = (OUT_WD_C - (r_cnt & OUT_MASK)) & OUT_MASK;
    assign w_countBits = (r_state == S_HDR) || (r_state == S_BHDR) || (r_state == S_DATA) ||
                         (r_state == S_EOB) || (r_state == S_ALIGN);
    assign w_lstHs    = r_outVal && r_outLst && out_rdy_i;

    assign tok_rdy_o  = (r_state == S_DATA) && w_pushOk;
    assign out_val_o  = r_outVal;
    assign out_dat_o  = r_outDat;
    assign out_lst_o  = r_outLst;
    assign zlib_len_o = r_zlibLen;
    assign done_o     = r_done;

    // Select what the current state wants to append to the bit accumulator this cycle.
    always_comb begin
        w_push    = 1'b0;
        w_pushDat = 32'd0;
        w_pushLen = '0;
        case (r_state)
            S_HDR: begin
                if (w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushDat = {16'd0, ZLIB_HDR[7:0], ZLIB_HDR[15:8]};
                    w_pushLen = CNT_WD'(16);
                end
            end
            S_BHDR: begin
                if (tok_val_i && w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushDat = {29'd0, 1'b0, 1'b1, tok_fin_i};
                    w_pushLen = CNT_WD'(3);
                end
            end
            S_DATA: begin
                if (tok_val_i && w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushDat = 32'(tok_code_i);
                    w_pushLen = CNT_WD'(tok_len_i);
                end
            end
            S_EOB: begin
                if (w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushLen = CNT_WD'(7);
                end
            end
            S_ALIGN: begin
                if (w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushLen = CNT_WD'(w_alignPad);
                end
            end
            S_ADLER: begin
                if (w_pushOk && r_adlerFlag) begin
                    w_push    = 1'b1;
                    w_pushDat = bswap(r_adlerDat);
                    w_pushLen = CNT_WD'(32);
                end
            end
`ifdef BS_ZLIB_LEN_TRAILER_EN
            S_LEN: begin
                if (w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushDat = bswap(r_zlibLen);
                    w_pushLen = CNT_WD'(32);
                end
            end
`endif
            S_FLUSH: begin
                if (w_pushOk) begin
                    w_push    = 1'b1;
                    w_pushLen = w_flushPad;
                end
            end
            default: begin
            end
        endcase
    end

    // Merge the push into the accumulator after any pop; pushed bits are masked to their length.
    always_comb begin
        w_mask       = (w_pushLen >= CNT_WD'(32)) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << w_pushLen) - 32'd1);
        w_pushMasked = w_pushDat & w_mask;
        w_pushVec    = ACC_WD'(w_pushMasked);
        w_accShift   = w_popOk ? (r_acc >> OUT_WD) : r_acc;
        w_cntBase    = w_popOk ? (r_cnt - OUT_WD_C) : r_cnt;
        w_accNxt     = w_accShift;
        w_cntNxt     = w_cntBase;
        if (w_push) begin
            w_accNxt = w_accShift | (w_pushVec << w_cntBase);
            w_cntNxt = w_cntBase + w_pushLen;
        end
    end

    // Stream sequencing, Adler capture and byte accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fin       <= 1'b0;
            r_adlerFlag <= 1'b0;
            r_adlerDat  <= 32'd0;
            r_bitCnt    <= 32'd0;
            r_zlibLen   <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start_i) begin
                    r_adlerFlag <= 1'b0;
                end
            end else if (adler32_done_i) begin
                r_adlerFlag <= 1'b1;
                r_adlerDat  <= adler32_dat_i;
            end
            if (w_push && w_countBits) begin
                r_bitCnt <= r_bitCnt + 32'(w_pushLen);
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state   <= S_HDR;
                        r_bitCnt  <= 32'd0;
                        r_zlibLen <= 32'd0;
                        r_fin     <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (w_push) r_state <= S_BHDR;
                end
                S_BHDR: begin
                    if (w_push) begin
                        r_fin   <= tok_fin_i;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_push && tok_eob_i) r_state <= S_EOB;
                end
                S_EOB: begin
                    if (w_push) r_state <= r_fin ? S_ALIGN : S_BHDR;
                end
                S_ALIGN: begin
                    if (w_push) r_state <= S_ADLER;
                end
                S_ADLER: begin
                    if (w_push) begin
                        r_zlibLen <= (r_bitCnt + 32'd32) >> 3;
`ifdef BS_ZLIB_LEN_TRAILER_EN
                        r_state   <= S_LEN;
`else
                        r_state   <= S_FLUSH;
`endif
                    end
                end
`ifdef BS_ZLIB_LEN_TRAILER_EN
                S_LEN: begin
                    if (w_push) r_state <= S_FLUSH;
                end
`endif
                S_FLUSH: begin
                    if (w_push) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_lstHs) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Accumulator update and output word register; a pending word holds until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_outVal <= 1'b0;
            r_outDat <= '0;
            r_outLst <= 1'b0;
        end else begin
            r_acc <= w_accNxt;
            r_cnt <= w_cntNxt;
            if (w_popOk) begin
                r_outVal <= 1'b1;
                r_outDat <= r_acc[OUT_WD-1:0];
                r_outLst <= (r_state == S_DRAIN) && (r_cnt == OUT_WD_C);
            end else if (out_rdy_i) begin
                r_outVal <= 1'b0;
                r_outLst <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bs_zlib_packer.sv
// tb_bs_zlib_packer: scoreboard bench for bs_zlib_packer. A bit-list reference model builds the
// expected zlib stream per transaction; a monitor compares every accepted output word.
// Honours BS_ZLIB_LEN_TRAILER_EN in the reference model when the design is built with it.
module tb_bs_zlib_packer;

   localparam int          OUT_WD  = 32;
   localparam int          CODE_WD = 19;
   localparam int          LEN_WD  = 5;
   localparam logic [15:0] HDR     = 16'h7801;

   typedef struct {
      logic [31:0] code;
      int          len;
      bit          eob;
      bit          fin;
   } tok_t;

   logic               clk;
   logic               rst;
   logic               start_i;
   logic               tok_val_i;
   logic               tok_rdy_o;
   logic [CODE_WD-1:0] tok_code_i;
   logic [LEN_WD-1:0]  tok_len_i;
   logic               tok_eob_i;
   logic               tok_fin_i;
   logic               adler32_done_i;
   logic [31:0]        adler32_dat_i;
   logic               out_val_o;
   logic               out_rdy_i;
   logic [OUT_WD-1:0]  out_dat_o;
   logic               out_lst_o;
   logic [31:0]        zlib_len_o;
   logic               done_o;

   int               nChecks = 0;
   int               nPass   = 0;
   logic [OUT_WD:0]  sbQ[$];
   bit               mBits[$];
   tok_t             toks[$];
   bit               stallForce = 0;
   int               rdyMode = 0;

   bs_zlib_packer #(
      .OUT_WD(OUT_WD), .CODE_WD(CODE_WD), .LEN_WD(LEN_WD), .ZLIB_HDR(HDR)
   ) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .tok_val_i(tok_val_i), .tok_rdy_o(tok_rdy_o), .tok_code_i(tok_code_i),
      .tok_len_i(tok_len_i), .tok_eob_i(tok_eob_i), .tok_fin_i(tok_fin_i),
      .adler32_done_i(adler32_done_i), .adler32_dat_i(adler32_dat_i),
      .out_val_o(out_val_o), .out_rdy_i(out_rdy_i), .out_dat_o(out_dat_o),
      .out_lst_o(out_lst_o), .zlib_len_o(zlib_len_o), .done_o(done_o)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic addBits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) mBits.push_back(v[i]);
   endtask

   // Reference: the stream as a flat list of bits in emission order, then cut into words.
   task automatic modelStream(input logic [31:0] adler, output int expLen);
      bit newBlk;
      int nWords;
      logic [OUT_WD:0] e;
      mBits.delete();
      addBits(32'(HDR[15:8]), 8);
      addBits(32'(HDR[7:0]), 8);
      newBlk = 1;
      foreach (toks[i]) begin
         if (newBlk) begin
            mBits.push_back(toks[i].fin);
            mBits.push_back(1'b1);
            mBits.push_back(1'b0);
            newBlk = 0;
         end
         addBits(toks[i].code, toks[i].len);
         if (toks[i].eob) begin
            addBits(32'd0, 7);
            newBlk = 1;
         end
      end
      while (mBits.size() % 8 != 0) mBits.push_back(1'b0);
      for (int k = 3; k >= 0; k--) addBits(adler >> (8 * k), 8);
      expLen = mBits.size() / 8;
`ifdef BS_ZLIB_LEN_TRAILER_EN
      for (int k = 3; k >= 0; k--) addBits(32'(expLen) >> (8 * k), 8);
`endif
      while (mBits.size() % OUT_WD != 0) mBits.push_back(1'b0);
      nWords = mBits.size() / OUT_WD;
      for (int w = 0; w < nWords; w++) begin
         e = '0;
         for (int b = 0; b < OUT_WD; b++) e[b] = mBits[w * OUT_WD + b];
         e[OUT_WD] = (w == nWords - 1);
         sbQ.push_back(e);
      end
   endtask

   // Random backpressure, forced low while a stall window is open.
   initial begin
      out_rdy_i = 0;
      forever begin
         @(negedge clk);
         if (stallForce) out_rdy_i = 0;
         else if (rdyMode == 0) out_rdy_i = 1;
         else out_rdy_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops the scoreboard on each accepted word and checks hold and done timing.
   initial begin
      logic [OUT_WD:0]   exp;
      logic [OUT_WD-1:0] prevDat;
      logic              prevLst;
      bit                prevStall;
      bit                prevLstHs;
      prevStall = 0;
      prevLstHs = 0;
      prevDat   = '0;
      prevLst   = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            prevStall = 0;
            prevLstHs = 0;
         end else begin
            if (prevStall) begin
               checkOutput("holdVal", 64'(out_val_o), 64'd1);
               checkOutput("holdDat", 64'(out_dat_o), 64'(prevDat));
               checkOutput("holdLst", 64'(out_lst_o), 64'(prevLst));
            end
            if (done_o || prevLstHs) checkOutput("donePulse", 64'(done_o), 64'(prevLstHs));
            prevLstHs = 0;
            if (out_val_o && out_rdy_i) begin
               if (sbQ.size() == 0) begin
                  nChecks++;
                  $display("[TB] FAIL extraWord: got 0x%0h, expected no word", out_dat_o);
               end else begin
                  exp = sbQ.pop_front();
                  checkOutput("word", 64'(out_dat_o), 64'(exp[OUT_WD-1:0]));
                  checkOutput("wordLst", 64'(out_lst_o), 64'(exp[OUT_WD]));
                  prevLstHs = exp[OUT_WD];
               end
            end
            prevStall = out_val_o && !out_rdy_i;
            prevDat   = out_dat_o;
            prevLst   = out_lst_o;
         end
      end
   end

   task automatic makeTokens(input int nBlk, input int nTok, input int minLen, input int maxLen,
                             input bit directed);
      int n;
      tok_t t;
      toks.delete();
      for (int b = 0; b < nBlk; b++) begin
         n = directed ? 1 : ((nTok > 0) ? nTok : $urandom_range(1, 5));
         for (int i = 0; i < n; i++) begin
            t.len  = directed ? 8 : $urandom_range(minLen, maxLen);
            t.code = directed ? 32'h89 : ($urandom() & ((32'd1 << t.len) - 32'd1));
            t.eob  = (i == n - 1);
            t.fin  = (b == nBlk - 1);
            toks.push_back(t);
         end
      end
   endtask

   task automatic sendTok(input tok_t t);
      int w;
      tok_val_i  = 1;
      tok_code_i = CODE_WD'(t.code);
      tok_len_i  = LEN_WD'(t.len);
      tok_eob_i  = t.eob;
      tok_fin_i  = t.fin;
      w = 0;
      while (!tok_rdy_o && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         nChecks++;
         $display("[TB] FAIL tokAccept: token still pending after %0d cycles, expected acceptance", w);
      end else begin
         @(negedge clk);
      end
      tok_val_i = 0;
   endtask

   task automatic applyStimulus(input int nBlk, input int nTok, input int minLen, input int maxLen,
                                input bit directed, input bit adlerEarly, input int adlerDelay,
                                input bit doStall);
      logic [31:0] adler;
      int expLen;
      int w;
      makeTokens(nBlk, nTok, minLen, maxLen, directed);
      adler = directed ? 32'h0062_0062 : $urandom();
      modelStream(adler, expLen);
      @(negedge clk);
      start_i = 1;
      @(negedge clk);
      start_i = 0;
      if (adlerEarly) begin
         adler32_dat_i  = adler;
         adler32_done_i = 1;
         @(negedge clk);
         adler32_done_i = 0;
      end
      fork
         begin
            foreach (toks[i]) begin
               sendTok(toks[i]);
               if (i == 0) begin
                  start_i = 1;
                  @(negedge clk);
                  start_i = 0;
               end
            end
         end
         begin
            if (doStall) begin
               repeat (6) @(negedge clk);
               stallForce = 1;
               repeat (20) @(negedge clk);
               #1;
               checkOutput("tokRdyStall", 64'(tok_rdy_o), 64'd0);
               stallForce = 0;
            end
         end
      join
      if (!adlerEarly) begin
         repeat (adlerDelay) @(negedge clk);
         adler32_dat_i  = adler;
         adler32_done_i = 1;
         @(negedge clk);
         adler32_done_i = 0;
      end
      w = 0;
      while (w < 3000) begin
         @(negedge clk);
         #1;
         if (done_o) break;
         w++;
      end
      if (w >= 3000) begin
         nChecks++;
         $display("[TB] FAIL doneWait: no done_o after %0d cycles, expected a done pulse", w);
         rst = 1;
         @(negedge clk);
         sbQ.delete();
         rst = 0;
      end else begin
         checkOutput("zlibLen", 64'(zlib_len_o), 64'(expLen));
         checkOutput("sbEmpty", 64'(sbQ.size()), 64'd0);
         checkOutput("idleTokRdy", 64'(tok_rdy_o), 64'd0);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "OutVal"}, 64'(out_val_o), 64'd0);
      checkOutput({tag, "OutLst"}, 64'(out_lst_o), 64'd0);
      checkOutput({tag, "OutDat"}, 64'(out_dat_o), 64'd0);
      checkOutput({tag, "TokRdy"}, 64'(tok_rdy_o), 64'd0);
      checkOutput({tag, "Done"}, 64'(done_o), 64'd0);
      checkOutput({tag, "ZlibLen"}, 64'(zlib_len_o), 64'd0);
   endtask

   // Abort a stream with reset in the middle of DATA; nothing of it may survive.
   task automatic applyAbort();
      int expLen;
      makeTokens(1, 6, 4, 19, 0);
      modelStream($urandom(), expLen);
      @(negedge clk);
      start_i = 1;
      @(negedge clk);
      start_i = 0;
      for (int i = 0; i < 3; i++) sendTok(toks[i]);
      rst       = 1;
      tok_val_i = 0;
      #1;
      sbQ.delete();
      checkResetOutputs("abort");
      @(negedge clk);
      rst = 0;
   endtask

   // Test sequence: reset, directed streams, random streams, stall, abort, recovery.
   initial begin
      rst            = 1;
      start_i        = 0;
      tok_val_i      = 0;
      tok_code_i     = '0;
      tok_len_i      = '0;
      tok_eob_i      = 0;
      tok_fin_i      = 0;
      adler32_done_i = 0;
      adler32_dat_i  = '0;
      repeat (3) @(negedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 0;

      rdyMode = 0;
      applyStimulus(1, 1, 8, 8, 1, 0, 3, 0);
      applyStimulus(1, 1, 8, 8, 1, 0, 15, 0);
      applyStimulus(2, 1, 8, 8, 1, 1, 0, 0);

      rdyMode = 1;
      for (int i = 0; i < 12; i++) begin
         applyStimulus($urandom_range(1, 3), 0, 1, 19, 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 20), 0);
      end
      applyStimulus(1, 12, 8, 19, 0, 0, 2, 1);
      applyStimulus(2, 12, 8, 19, 0, 1, 0, 1);

      applyAbort();
      rdyMode = 0;
      applyStimulus(1, 1, 8, 8, 1, 0, 3, 0);

      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
